// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares a single ALU between NUM_REQ requesters.
// Only one ALU operation is outstanding at a time. A watchdog aborts the operation if the ALU never answers.
module alu_req_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int TIMEOUT    = 64
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VLD,
    output logic [NUM_REQ-1:0]            REQ_RDY,
    input  logic [NUM_REQ*4-1:0]          REQ_OP,
    input  logic [NUM_REQ*2-1:0]          REQ_MOVI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_B,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_MEM,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_IMM,
    input  logic                          ALU_RDY,
    output logic                          ALU_ACT,
    output logic [3:0]                    ALU_OP,
    output logic [1:0]                    ALU_MOVI,
    output logic [DATA_WIDTH-1:0]         ALU_REG_A,
    output logic [DATA_WIDTH-1:0]         ALU_REG_B,
    output logic [DATA_WIDTH-1:0]         ALU_MEM,
    output logic [DATA_WIDTH-1:0]         ALU_IMM,
    input  logic [DATA_WIDTH-1:0]         EX_ALU,
    input  logic                          EX_ALU_VLD,
    output logic                          RSP_VLD,
    output logic [ID_WIDTH-1:0]           RSP_ID,
    output logic [DATA_WIDTH-1:0]         RSP_DATA,
    input  logic                          RSP_RDY,
    output logic                          TIMEOUT_ERR
);

    // The watchdog never has to hold a value larger than TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [ID_WIDTH-1:0]     gnt_q;
    logic [WD_W-1:0]         wd_q;
    logic                    act_q;
    logic [3:0]              op_q;
    logic [1:0]              movi_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   mem_q;
    logic [DATA_WIDTH-1:0]   imm_q;
    logic                    rsp_vld_q;
    logic [ID_WIDTH-1:0]     rsp_id_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    tmo_q;

    logic                    any_d;
    logic [ID_WIDTH-1:0]     gnt_d;
    logic                    grant;
    logic [3:0]              op_d;
    logic [1:0]              movi_d;
    logic [DATA_WIDTH-1:0]   a_d;
    logic [DATA_WIDTH-1:0]   b_d;
    logic [DATA_WIDTH-1:0]   mem_d;
    logic [DATA_WIDTH-1:0]   imm_d;

    // The scan starts one slot past the last-served requester and wraps around.
    always_comb begin : rr_pick
        int idx;
        idx   = 0;
        any_d = 1'b0;
        gnt_d = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_d && REQ_VLD[idx]) begin
                any_d = 1'b1;
                gnt_d = ID_WIDTH'(idx);
            end
        end
    end

    // REQ_RDY is held low while reset is asserted, because the reset edge will discard anything accepted in that cycle.
    assign grant = RST && (state_q == S_IDLE) && ALU_RDY && any_d;

    always_comb begin : rdy_decode
        REQ_RDY = '0;
        if (grant) begin
            REQ_RDY[gnt_d] = 1'b1;
        end
    end

    always_comb begin : grant_mux
        op_d   = REQ_OP[int'(gnt_d)*4 +: 4];
        movi_d = REQ_MOVI[int'(gnt_d)*2 +: 2];
        a_d    = REQ_A[int'(gnt_d)*DATA_WIDTH +: DATA_WIDTH];
        b_d    = REQ_B[int'(gnt_d)*DATA_WIDTH +: DATA_WIDTH];
        mem_d  = REQ_MEM[int'(gnt_d)*DATA_WIDTH +: DATA_WIDTH];
        imm_d  = REQ_IMM[int'(gnt_d)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
            gnt_q      <= '0;
            wd_q       <= '0;
            act_q      <= 1'b0;
            op_q       <= '0;
            movi_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mem_q      <= '0;
            imm_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            act_q <= 1'b0;
            tmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        gnt_q   <= gnt_d;
                        op_q    <= op_d;
                        movi_q  <= movi_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        mem_q   <= mem_d;
                        imm_q   <= imm_d;
                        act_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                // A result that arrives on the last counted cycle still completes normally.
                S_WAIT: begin
                    if (EX_ALU_VLD) begin
                        rsp_vld_q  <= 1'b1;
                        rsp_id_q   <= gnt_q;
                        rsp_data_q <= EX_ALU;
                        ptr_q      <= gnt_q;
                        state_q    <= S_RESP;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        ptr_q   <= gnt_q;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_RESP: begin
                    if (RSP_RDY) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ALU_ACT     = act_q;
    assign ALU_OP      = op_q;
    assign ALU_MOVI    = movi_q;
    assign ALU_REG_A   = a_q;
    assign ALU_REG_B   = b_q;
    assign ALU_MEM     = mem_q;
    assign ALU_IMM     = imm_q;
    assign RSP_VLD     = rsp_vld_q;
    assign RSP_ID      = rsp_id_q;
    assign RSP_DATA    = rsp_data_q;
    assign TIMEOUT_ERR = tmo_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter. Directed scenarios plus randomized transactions,
// all checked against a transaction-level round-robin and ALU reference model.
module tb_alu_req_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int TO = 64;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     REQ_VLD;
    logic [NR-1:0]     REQ_RDY;
    logic [NR*4-1:0]   REQ_OP;
    logic [NR*2-1:0]   REQ_MOVI;
    logic [NR*DW-1:0]  REQ_A, REQ_B, REQ_MEM, REQ_IMM;
    logic              ALU_RDY, ALU_ACT;
    logic [3:0]        ALU_OP;
    logic [1:0]        ALU_MOVI;
    logic [DW-1:0]     ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM;
    logic [DW-1:0]     EX_ALU;
    logic              EX_ALU_VLD;
    logic              RSP_VLD;
    logic [IW-1:0]     RSP_ID;
    logic [DW-1:0]     RSP_DATA;
    logic              RSP_RDY;
    logic              TIMEOUT_ERR;

    int vec_cnt = 0;
    int err_cnt = 0;
    int m_ptr;

    wire [NR+1+4+2+4*DW+1+IW+DW+1-1:0] all_out = {REQ_RDY, ALU_ACT, ALU_OP, ALU_MOVI,
        ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM, RSP_VLD, RSP_ID, RSP_DATA, TIMEOUT_ERR};

    alu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_MEM(REQ_MEM), .REQ_IMM(REQ_IMM),
        .ALU_RDY(ALU_RDY), .ALU_ACT(ALU_ACT), .ALU_OP(ALU_OP), .ALU_MOVI(ALU_MOVI),
        .ALU_REG_A(ALU_REG_A), .ALU_REG_B(ALU_REG_B), .ALU_MEM(ALU_MEM), .ALU_IMM(ALU_IMM),
        .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD),
        .RSP_VLD(RSP_VLD), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_RDY(RSP_RDY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference arbiter: the first valid requester found after the last-served one, taken modulo NR.
    function automatic int rr_pick(input logic [NR-1:0] vld, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (vld[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] alu_model(input logic [3:0] op, input logic [1:0] movi,
            input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m,
            input logic [DW-1:0] imm);
        logic [DW-1:0] bb;
        bb = (movi == 2'b01) ? m : (movi == 2'b10) ? imm : b;
        case (op)
            4'd0:    return a + bb;
            4'd1:    return a - bb;
            4'd2:    return a & bb;
            4'd3:    return a | bb;
            4'd4:    return a ^ bb;
            default: return a;
        endcase
    endfunction

    task automatic idle_inputs();
        REQ_VLD    = '0;
        ALU_RDY    = 1'b0;
        EX_ALU     = '0;
        EX_ALU_VLD = 1'b0;
        RSP_RDY    = 1'b0;
    endtask

    task automatic randomize_ops();
        REQ_OP  = (NR*4)'($urandom);
        for (int i = 0; i < NR; i++) REQ_MOVI[2*i +: 2] = 2'($urandom_range(0, 2));
        REQ_A   = (NR*DW)'($urandom);
        REQ_B   = (NR*DW)'($urandom);
        REQ_MEM = (NR*DW)'($urandom);
        REQ_IMM = (NR*DW)'($urandom);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_inputs();
        randomize_ops();
        REQ_VLD = '1; ALU_RDY = 1'b1; EX_ALU_VLD = 1'b1; EX_ALU = 8'hA5;
        repeat (3) @(negedge CLK);
        vec_cnt++;
        if (all_out !== '0) begin
            err_cnt++; $display("FAIL reset_held: outputs %h, required 0", all_out);
        end
        idle_inputs();
        RST = 1'b1;
        m_ptr = NR - 1;
        @(negedge CLK);
        vec_cnt++;
        if (all_out !== '0) begin
            err_cnt++; $display("FAIL reset_release: outputs %h, required 0", all_out);
        end
    endtask

    task automatic test_single();
        idle_inputs();
        randomize_ops();
        REQ_OP[11:8] = 4'h0; REQ_A[23:16] = 8'h05; REQ_B[23:16] = 8'h03; REQ_MOVI[5:4] = 2'b00;
        REQ_VLD = 4'b0100; ALU_RDY = 1'b1; RSP_RDY = 1'b1;
        #1;
        vec_cnt++;
        if (REQ_RDY !== 4'b0100) begin
            err_cnt++; $display("FAIL single_grant: REQ_RDY %b, required 0100", REQ_RDY);
        end
        @(negedge CLK);
        REQ_VLD = '0;
        vec_cnt++;
        if (ALU_ACT !== 1'b1 || ALU_OP !== 4'h0 || ALU_REG_A !== 8'h05 || ALU_REG_B !== 8'h03 ||
            ALU_MOVI !== 2'b00 || ALU_MEM !== REQ_MEM[23:16] || ALU_IMM !== REQ_IMM[23:16]) begin
            err_cnt++; $display("FAIL single_issue: act %b op %h a %h b %h movi %b, required 1 0 05 03 00",
                ALU_ACT, ALU_OP, ALU_REG_A, ALU_REG_B, ALU_MOVI);
        end
        @(negedge CLK);
        vec_cnt++;
        if (ALU_ACT !== 1'b0 || RSP_VLD !== 1'b0) begin
            err_cnt++; $display("FAIL single_act_pulse: act %b rsp %b, required 0 0", ALU_ACT, RSP_VLD);
        end
        @(negedge CLK);
        EX_ALU_VLD = 1'b1; EX_ALU = 8'h08;
        @(negedge CLK);
        EX_ALU_VLD = 1'b0;
        vec_cnt++;
        if (RSP_VLD !== 1'b1 || RSP_ID !== 2'd2 || RSP_DATA !== 8'h08) begin
            err_cnt++; $display("FAIL single_rsp: vld %b id %0d data %h, required 1 2 08", RSP_VLD, RSP_ID, RSP_DATA);
        end
        @(negedge CLK);
        vec_cnt++;
        if (RSP_VLD !== 1'b0) begin
            err_cnt++; $display("FAIL single_rsp_clear: vld %b, required 0", RSP_VLD);
        end
        m_ptr = 2;
    endtask

    task automatic test_fairness();
        int want [5] = '{0, 1, 2, 3, 0};
        idle_inputs();
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        m_ptr = NR - 1;
        randomize_ops();
        REQ_VLD = '1; ALU_RDY = 1'b1; RSP_RDY = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            vec_cnt++;
            if (REQ_RDY !== NR'(1 << want[g])) begin
                err_cnt++; $display("FAIL fair_grant%0d: REQ_RDY %b, required req %0d", g, REQ_RDY, want[g]);
            end
            @(negedge CLK);
            vec_cnt++;
            if (ALU_ACT !== 1'b1 || ALU_OP !== REQ_OP[4*want[g] +: 4]) begin
                err_cnt++; $display("FAIL fair_issue%0d: act %b op %h, required 1 %h", g, ALU_ACT, ALU_OP, REQ_OP[4*want[g] +: 4]);
            end
            @(negedge CLK);
            EX_ALU_VLD = 1'b1; EX_ALU = 8'(g * 17 + 1);
            @(negedge CLK);
            EX_ALU_VLD = 1'b0;
            vec_cnt++;
            if (RSP_VLD !== 1'b1 || RSP_ID !== IW'(want[g]) || RSP_DATA !== 8'(g * 17 + 1) || REQ_RDY !== '0) begin
                err_cnt++; $display("FAIL fair_rsp%0d: vld %b id %0d data %h rdy %b, required 1 %0d %h 0000",
                    g, RSP_VLD, RSP_ID, RSP_DATA, REQ_RDY, want[g], 8'(g * 17 + 1));
            end
            @(negedge CLK);
        end
        REQ_VLD = '0;
        m_ptr = 0;
    endtask

    task automatic test_backpressure();
        int w;
        idle_inputs();
        randomize_ops();
        REQ_VLD = '1; ALU_RDY = 1'b1;
        w = rr_pick(REQ_VLD, m_ptr);
        #1;
        vec_cnt++;
        if (REQ_RDY !== NR'(1 << w)) begin
            err_cnt++; $display("FAIL bp_grant: REQ_RDY %b, required req %0d", REQ_RDY, w);
        end
        @(negedge CLK);
        @(negedge CLK);
        EX_ALU_VLD = 1'b1; EX_ALU = 8'h6E;
        @(negedge CLK);
        EX_ALU_VLD = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (RSP_VLD !== 1'b1 || RSP_ID !== IW'(w) || RSP_DATA !== 8'h6E || REQ_RDY !== '0) begin
                err_cnt++; $display("FAIL bp_hold%0d: vld %b id %0d data %h rdy %b, required 1 %0d 6e 0000",
                    k, RSP_VLD, RSP_ID, RSP_DATA, REQ_RDY, w);
            end
            if (k == 4) begin
                RSP_RDY = 1'b1; REQ_VLD = '0;
            end
            @(negedge CLK);
        end
        vec_cnt++;
        if (RSP_VLD !== 1'b0) begin
            err_cnt++; $display("FAIL bp_release: vld %b, required 0", RSP_VLD);
        end
        m_ptr = w;
    endtask

    task automatic test_watchdog();
        int w, w2;
        int bad;
        idle_inputs();
        randomize_ops();
        REQ_VLD = 4'b0011; ALU_RDY = 1'b1; RSP_RDY = 1'b1;
        w = rr_pick(REQ_VLD, m_ptr);
        #1;
        vec_cnt++;
        if (REQ_RDY !== NR'(1 << w)) begin
            err_cnt++; $display("FAIL wd_grant: REQ_RDY %b, required req %0d", REQ_RDY, w);
        end
        @(negedge CLK);
        bad = 0;
        for (int k = 0; k < TO; k++) begin
            @(negedge CLK);
            if (TIMEOUT_ERR !== 1'b0 || RSP_VLD !== 1'b0 || REQ_RDY !== '0) bad++;
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++; $display("FAIL wd_quiet: %0d bad cycles while waiting, required 0", bad);
        end
        @(negedge CLK);
        m_ptr = w;
        w2 = rr_pick(REQ_VLD, m_ptr);
        vec_cnt++;
        if (TIMEOUT_ERR !== 1'b1 || RSP_VLD !== 1'b0 || REQ_RDY !== NR'(1 << w2)) begin
            err_cnt++; $display("FAIL wd_abort: err %b rsp %b rdy %b, required 1 0 req %0d", TIMEOUT_ERR, RSP_VLD, REQ_RDY, w2);
        end
        @(negedge CLK);
        REQ_VLD = '0;
        vec_cnt++;
        if (TIMEOUT_ERR !== 1'b0 || ALU_ACT !== 1'b1 || ALU_REG_A !== REQ_A[DW*w2 +: DW]) begin
            err_cnt++; $display("FAIL wd_regrant: err %b act %b a %h, required 0 1 %h", TIMEOUT_ERR, ALU_ACT, ALU_REG_A, REQ_A[DW*w2 +: DW]);
        end
        bad = 0;
        for (int k = 0; k < TO - 1; k++) begin
            @(negedge CLK);
            if (TIMEOUT_ERR !== 1'b0 || RSP_VLD !== 1'b0) bad++;
        end
        @(negedge CLK);
        EX_ALU_VLD = 1'b1; EX_ALU = 8'hC3;
        @(negedge CLK);
        EX_ALU_VLD = 1'b0;
        vec_cnt++;
        if (bad != 0 || TIMEOUT_ERR !== 1'b0 || RSP_VLD !== 1'b1 || RSP_ID !== IW'(w2) || RSP_DATA !== 8'hC3) begin
            err_cnt++; $display("FAIL wd_last_cycle: bad %0d err %b vld %b id %0d data %h, required 0 0 1 %0d c3",
                bad, TIMEOUT_ERR, RSP_VLD, RSP_ID, RSP_DATA, w2);
        end
        @(negedge CLK);
        vec_cnt++;
        if (RSP_VLD !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
            err_cnt++; $display("FAIL wd_after: vld %b err %b, required 0 0", RSP_VLD, TIMEOUT_ERR);
        end
        m_ptr = w2;
    endtask

    task automatic test_alu_not_rdy();
        int bad;
        idle_inputs();
        randomize_ops();
        REQ_VLD = 4'b0001; RSP_RDY = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (REQ_RDY !== '0 || ALU_ACT !== 1'b0) bad++;
            @(negedge CLK);
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++; $display("FAIL busy_hold: %0d cycles with REQ_RDY or ACT set, required 0", bad);
        end
        ALU_RDY = 1'b1;
        #1;
        vec_cnt++;
        if (REQ_RDY !== 4'b0001) begin
            err_cnt++; $display("FAIL busy_grant: REQ_RDY %b, required 0001", REQ_RDY);
        end
        @(negedge CLK);
        REQ_VLD = '0; ALU_RDY = 1'b0;
        vec_cnt++;
        if (ALU_ACT !== 1'b1 || ALU_REG_A !== REQ_A[DW-1:0]) begin
            err_cnt++; $display("FAIL busy_issue: act %b a %h, required 1 %h", ALU_ACT, ALU_REG_A, REQ_A[DW-1:0]);
        end
        @(negedge CLK);
        EX_ALU_VLD = 1'b1; EX_ALU = 8'h3C;
        @(negedge CLK);
        EX_ALU_VLD = 1'b0;
        vec_cnt++;
        if (RSP_VLD !== 1'b1 || RSP_ID !== 2'd0 || RSP_DATA !== 8'h3C) begin
            err_cnt++; $display("FAIL busy_rsp: vld %b id %0d data %h, required 1 0 3c", RSP_VLD, RSP_ID, RSP_DATA);
        end
        @(negedge CLK);
        m_ptr = 0;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        randomize_ops();
        REQ_A[31:24] = 8'h5A;
        REQ_VLD = 4'b1000; ALU_RDY = 1'b1; RSP_RDY = 1'b1;
        #1;
        vec_cnt++;
        if (REQ_RDY !== 4'b1000) begin
            err_cnt++; $display("FAIL rstmid_grant: REQ_RDY %b, required 1000", REQ_RDY);
        end
        @(negedge CLK);
        REQ_VLD = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        vec_cnt++;
        if (all_out !== '0) begin
            err_cnt++; $display("FAIL rstmid_clear: outputs %h, required 0", all_out);
        end
        RST = 1'b1; ALU_RDY = 1'b0; EX_ALU_VLD = 1'b1; EX_ALU = 8'hEE;
        @(negedge CLK);
        EX_ALU_VLD = 1'b0;
        vec_cnt++;
        if (all_out !== '0) begin
            err_cnt++; $display("FAIL rstmid_stray_ex: outputs %h, required 0", all_out);
        end
        m_ptr = NR - 1;
        REQ_VLD = '1; ALU_RDY = 1'b1;
        #1;
        vec_cnt++;
        if (REQ_RDY !== NR'(1 << rr_pick(REQ_VLD, m_ptr))) begin
            err_cnt++; $display("FAIL rstmid_ptr: REQ_RDY %b, required 0001", REQ_RDY);
        end
        @(negedge CLK);
        REQ_VLD = '0;
        @(negedge CLK);
        EX_ALU_VLD = 1'b1; EX_ALU = 8'h11;
        @(negedge CLK);
        EX_ALU_VLD = 1'b0;
        vec_cnt++;
        if (RSP_VLD !== 1'b1 || RSP_ID !== 2'd0 || RSP_DATA !== 8'h11) begin
            err_cnt++; $display("FAIL rstmid_rsp: vld %b id %0d data %h, required 1 0 11", RSP_VLD, RSP_ID, RSP_DATA);
        end
        @(negedge CLK);
        m_ptr = 0;
    endtask

    task automatic test_random();
        int w, d, h, nbusy;
        logic [3:0]    e_op;
        logic [1:0]    e_movi;
        logic [DW-1:0] e_a, e_b, e_m, e_i, e_res;
        logic [NR-1:0] vld;
        idle_inputs();
        for (int n = 0; n < 40; n++) begin
            randomize_ops();
            vld = NR'($urandom_range(1, (1 << NR) - 1));
            REQ_VLD = vld; RSP_RDY = 1'b0; EX_ALU_VLD = 1'b0; ALU_RDY = 1'b0;
            nbusy = $urandom_range(0, 2);
            for (int k = 0; k < nbusy; k++) begin
                #1;
                vec_cnt++;
                if (REQ_RDY !== '0) begin
                    err_cnt++; $display("FAIL rnd_busy%0d: REQ_RDY %b, required 0", n, REQ_RDY);
                end
                @(negedge CLK);
            end
            ALU_RDY = 1'b1;
            w = rr_pick(vld, m_ptr);
            e_op = REQ_OP[4*w +: 4]; e_movi = REQ_MOVI[2*w +: 2];
            e_a = REQ_A[DW*w +: DW]; e_b = REQ_B[DW*w +: DW];
            e_m = REQ_MEM[DW*w +: DW]; e_i = REQ_IMM[DW*w +: DW];
            e_res = alu_model(e_op, e_movi, e_a, e_b, e_m, e_i);
            #1;
            vec_cnt++;
            if (REQ_RDY !== NR'(1 << w)) begin
                err_cnt++; $display("FAIL rnd_grant%0d: REQ_RDY %b, required req %0d (vld %b)", n, REQ_RDY, w, vld);
            end
            @(negedge CLK);
            REQ_VLD = NR'($urandom);
            randomize_ops();
            vec_cnt++;
            if (ALU_ACT !== 1'b1 || ALU_OP !== e_op || ALU_MOVI !== e_movi || ALU_REG_A !== e_a ||
                ALU_REG_B !== e_b || ALU_MEM !== e_m || ALU_IMM !== e_i) begin
                err_cnt++; $display("FAIL rnd_issue%0d: act %b op %h movi %b a %h b %h m %h i %h, required 1 %h %b %h %h %h %h",
                    n, ALU_ACT, ALU_OP, ALU_MOVI, ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM, e_op, e_movi, e_a, e_b, e_m, e_i);
            end
            if ($urandom_range(0, 3) == 0) begin
                EX_ALU_VLD = 1'b1; EX_ALU = ~e_res;
            end
            d = $urandom_range(1, 6);
            for (int k = 1; k < d; k++) begin
                @(negedge CLK);
                EX_ALU_VLD = 1'b0;
                vec_cnt++;
                if (ALU_ACT !== 1'b0 || RSP_VLD !== 1'b0 || REQ_RDY !== '0 || TIMEOUT_ERR !== 1'b0) begin
                    err_cnt++; $display("FAIL rnd_wait%0d: act %b rsp %b rdy %b err %b, required all 0",
                        n, ALU_ACT, RSP_VLD, REQ_RDY, TIMEOUT_ERR);
                end
            end
            @(negedge CLK);
            EX_ALU_VLD = 1'b1; EX_ALU = e_res;
            @(negedge CLK);
            EX_ALU_VLD = 1'b0;
            h = $urandom_range(0, 3);
            for (int k = 0; k <= h; k++) begin
                vec_cnt++;
                if (RSP_VLD !== 1'b1 || RSP_ID !== IW'(w) || RSP_DATA !== e_res || REQ_RDY !== '0 || ALU_ACT !== 1'b0) begin
                    err_cnt++; $display("FAIL rnd_resp%0d: vld %b id %0d data %h rdy %b act %b, required 1 %0d %h 0 0",
                        n, RSP_VLD, RSP_ID, RSP_DATA, REQ_RDY, ALU_ACT, w, e_res);
                end
                if (k == h) begin
                    RSP_RDY = 1'b1; REQ_VLD = '0; EX_ALU_VLD = 1'b0;
                end else begin
                    EX_ALU_VLD = 1'($urandom_range(0, 1)); EX_ALU = 8'($urandom);
                end
                @(negedge CLK);
            end
            EX_ALU_VLD = 1'b0; RSP_RDY = 1'b0;
            vec_cnt++;
            if (RSP_VLD !== 1'b0) begin
                err_cnt++; $display("FAIL rnd_release%0d: vld %b, required 0", n, RSP_VLD);
            end
            m_ptr = w;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_alu_not_rdy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
